// File: rtl/result_writeback.sv
// rtl/result_writeback.sv - clamps buffered filter results to pixels and writes them to the framebuffer controller
module result_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    // Pointers wrap naturally because DEPTH is a power of two; occupancy tracks push/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array carries no reset; stale entries are never visible because occupancy is cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);
endmodule

module result_writeback #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] pixel_count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              write_result,
    output logic [ADDR_W-1:0] address,
    output logic [7:0]        new_data,
    input  logic              done,
    output logic              busy,
    output logic              finished
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] remaining;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    // Signed result to unsigned 8-bit pixel: negatives floor at 0, anything above 255 saturates.
    function automatic logic [7:0] clamp_pixel(input logic [DATA_W-1:0] v);
        if (v[DATA_W-1]) begin
            return 8'h00;
        end else if (|v[DATA_W-2:8]) begin
            return 8'hFF;
        end else begin
            return v[7:0];
        end
    endfunction

    assign in_ready  = ~fifo_full;
    assign fifo_push = in_valid & ~fifo_full;
    assign fifo_pop  = (state == S_FETCH) & ~fifo_empty;
    assign busy      = (state != S_IDLE);
    assign finished  = (state == S_DONE);

    result_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (in_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Job sequencer: one write_result/done handshake per pixel, with a one-cycle RELEASE
    // so the controller always drops done before the next request is raised.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            remaining    <= '0;
            address      <= '0;
            new_data     <= '0;
            write_result <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    write_result <= 1'b0;
                    if (start) begin
                        address   <= base_addr;
                        remaining <= pixel_count;
                        state     <= (pixel_count == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (!fifo_empty) begin
                        new_data     <= clamp_pixel(fifo_head);
                        write_result <= 1'b1;
                        state        <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (done) begin
                        write_result <= 1'b0;
                        remaining    <= remaining - 1'b1;
                        state        <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    write_result <= 1'b0;
                    address      <= address + 1'b1;
                    state        <= (remaining == '0) ? S_DONE : S_FETCH;
                end
                S_DONE: begin
                    write_result <= 1'b0;
                    state        <= S_IDLE;
                end
                default: begin
                    write_result <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_result_writeback.sv
// tb/tb_result_writeback.sv - scoreboard bench for result_writeback
module tb_result_writeback;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [17:0] base_addr = '0;
    logic [17:0] pixel_count = '0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        write_result;
    logic [17:0] address;
    logic [7:0]  new_data;
    logic        done = 1'b0;
    logic        busy;
    logic        finished;

    int checks = 0;
    int failures = 0;

    logic [7:0]  data_q[$];
    logic [17:0] addr_q[$];
    int          gap_q[$];
    int          hi_q[$];
    int          fin_q[$];

    int          n_writes = 0;
    int          extra_delay = 0;
    int          lat_cnt = 0;
    logic        prev_wr = 1'b0;
    int          low_len = 0;
    int          high_len = 0;
    int          since_fall = 0;
    logic [17:0] cur_addr = '0;
    logic [7:0]  cur_data = '0;

    result_writeback dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .pixel_count  (pixel_count),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .write_result (write_result),
        .address      (address),
        .new_data     (new_data),
        .done         (done),
        .busy         (busy),
        .finished     (finished)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] clamp_model(input int v);
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    // Framebuffer controller model: done after 5 cycles (+extra_delay once), cleared when request drops.
    always @(negedge clk) begin
        if (reset || !write_result) begin
            done = 1'b0;
            lat_cnt = 0;
        end else if (!done) begin
            lat_cnt++;
            if (lat_cnt >= 5 + extra_delay) begin
                done = 1'b1;
                extra_delay = 0;
            end
        end
    end

    // Write monitor: pops the scoreboard on each request and logs gap/hold/finished timing.
    always @(negedge clk) begin
        if (reset) begin
            prev_wr = 1'b0;
            low_len = 0;
            since_fall = 0;
        end else begin
            if (write_result && !prev_wr) begin
                gap_q.push_back(low_len);
                high_len = 0;
                n_writes++;
                check("sb_pending", 32'((data_q.size() > 0) && (addr_q.size() > 0)), 32'd1);
                if (data_q.size() > 0 && addr_q.size() > 0) begin
                    check("wr_addr", 32'(address), 32'(addr_q.pop_front()));
                    check("wr_data", 32'(new_data), 32'(data_q.pop_front()));
                end
                cur_addr = address;
                cur_data = new_data;
            end else if (write_result) begin
                check("addr_stable", 32'(address), 32'(cur_addr));
                check("data_stable", 32'(new_data), 32'(cur_data));
            end
            if (write_result) high_len++;
            if (!write_result && prev_wr) begin
                hi_q.push_back(high_len);
                low_len = 0;
                since_fall = 0;
            end
            if (!write_result) low_len++;
            since_fall++;
            if (finished) fin_q.push_back(since_fall);
            prev_wr = write_result;
        end
    end

    task automatic clear_logs();
        gap_q.delete();
        hi_q.delete();
        fin_q.delete();
    endtask

    task automatic push_val(input int v);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data = v[15:0];
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("push_timeout", 32'(in_ready), 32'd1);
        if (in_ready) data_q.push_back(clamp_model(v));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic start_job(input logic [17:0] base, input logic [17:0] cnt);
        logic [17:0] a = base;
        for (int i = 0; i < int'(cnt); i++) begin
            addr_q.push_back(a);
            a = a + 18'd1;
        end
        @(negedge clk);
        start = 1'b1;
        base_addr = base;
        pixel_count = cnt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_finished(input int limit);
        for (int i = 0; i < limit && fin_q.size() == 0; i++) @(negedge clk);
        check("fin_timeout", 32'(fin_q.size() > 0), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wr"}, 32'(write_result), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        check({tag, "_fin"}, 32'(finished), 32'd0);
        check({tag, "_addr"}, 32'(address), 32'd0);
        check({tag, "_data"}, 32'(new_data), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int t;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;

        // Reset while a write is outstanding, with data still queued behind it.
        push_val(5);
        push_val(6);
        start_job(18'h100, 18'd2);
        t = 0;
        while (!write_result && t < 50) begin @(negedge clk); t++; end
        check("t1_wr_seen", 32'(write_result), 32'd1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_idle_outputs("midreset");
        data_q.delete();
        addr_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_logs();
        n0 = n_writes;
        start_job(18'h120, 18'd1);
        repeat (15) @(negedge clk);
        check("t1_fifo_empty", 32'(n_writes - n0), 32'd0);
        check("t1_busy_fetch", 32'(busy), 32'd1);
        push_val(77);
        wait_finished(100);

        // Basic job with clamp cases, data queued up front.
        clear_logs();
        push_val(10);
        push_val(-5);
        push_val(300);
        start_job(18'h00010, 18'd3);
        wait_finished(200);
        repeat (3) @(negedge clk);
        check("t2_fin_once", 32'(fin_q.size()), 32'd1);
        if (fin_q.size() > 0) check("t2_fin_after_rel", 32'(fin_q[0]), 32'd2);
        check("t2_gaps", 32'(gap_q.size()), 32'd3);
        if (gap_q.size() == 3) begin
            check("t2_gap1", 32'(gap_q[1]), 32'd2);
            check("t2_gap2", 32'(gap_q[2]), 32'd2);
        end

        // Fill FIFO without a job; ninth value held until room frees.
        clear_logs();
        for (int i = 0; i < 8; i++) push_val(i * 70 - 100);
        @(negedge clk);
        check("t3_full", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data = 16'(8 * 70 - 100);
        repeat (3) @(negedge clk);
        check("t3_held", 32'(in_ready), 32'd0);
        n0 = n_writes;
        start_job(18'h300, 18'd9);
        t = 0;
        while (!in_ready && t < 200) begin @(negedge clk); t++; end
        check("t3_room", 32'(in_ready), 32'd1);
        data_q.push_back(clamp_model(8 * 70 - 100));
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_finished(400);
        check("t3_nwrites", 32'(n_writes - n0), 32'd9);

        // Zero-length job.
        clear_logs();
        n0 = n_writes;
        start_job(18'h50, 18'd0);
        check("t4_fin", 32'(finished), 32'd1);
        check("t4_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t4_fin_drop", 32'(finished), 32'd0);
        check("t4_idle", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("t4_nowrite", 32'(n_writes - n0), 32'd0);
        check("t4_fin_once", 32'(fin_q.size()), 32'd1);

        // Address wrap at the top of the framebuffer.
        clear_logs();
        push_val(1);
        push_val(2);
        push_val(3);
        start_job(18'h3FFFE, 18'd3);
        wait_finished(200);

        // Slow controller on the first pixel, then FIFO starvation before the second.
        clear_logs();
        n0 = n_writes;
        extra_delay = 20;
        push_val(40);
        start_job(18'h200, 18'd2);
        t = 0;
        while (hi_q.size() == 0 && t < 200) begin @(negedge clk); t++; end
        check("t6_first_done", 32'(hi_q.size()), 32'd1);
        repeat (10) @(negedge clk);
        check("t6_starved", 32'(n_writes - n0), 32'd1);
        push_val(41);
        wait_finished(200);
        check("t6_nwrites", 32'(n_writes - n0), 32'd2);
        if (hi_q.size() > 0) check("t6_long_hold", 32'(hi_q[0] >= 25), 32'd1);

        repeat (2) @(negedge clk);
        check("sb_data_drained", 32'(data_q.size()), 32'd0);
        check("sb_addr_drained", 32'(addr_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
